// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register and its forwarding logic.
package id_ex_stage_pkg;

  localparam int XLEN = 32;

  // ALU operation codes carried through ALUControlE; unlisted codes pass through.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Operand source selects reported on ForwardAE/ForwardBE.
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Writeback result source encodings.
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // Everything the E stage holds; an all-zero value is the bubble.
  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic [1:0]      result_src;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic [2:0]      alu_control;
    logic            alu_src;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] pc_plus4;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } ex_regs_t;

  localparam ex_regs_t EX_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_forward_unit.sv
// Operand forwarding for one E-stage source: pick M, W or the registered value.
module forward_unit
  import id_ex_stage_pkg::*;
(
  input  logic            valid_e,
  input  logic [4:0]      rs_e,
  input  logic [XLEN-1:0] reg_val_e,
  input  logic            reg_write_m,
  input  logic [4:0]      rd_m,
  input  logic [XLEN-1:0] alu_result_m,
  input  logic            reg_write_w,
  input  logic [4:0]      rd_w,
  input  logic [XLEN-1:0] result_w,
  output logic [1:0]      fwd_sel,
  output logic [XLEN-1:0] fwd_val
);

  logic hit_m;
  logic hit_w;

  // x0 is hard-wired zero, so a producer targeting it never forwards.
  assign hit_m = valid_e && reg_write_m && (rd_m != 5'd0) && (rd_m == rs_e);
  assign hit_w = valid_e && reg_write_w && (rd_w != 5'd0) && (rd_w == rs_e);

  // M is the younger producer, so it wins over W when both match.
  always_comb begin
    fwd_sel = FWD_REG;
    fwd_val = reg_val_e;
    if (hit_m) begin
      fwd_sel = FWD_MEM;
      fwd_val = alu_result_m;
    end else if (hit_w) begin
      fwd_sel = FWD_WB;
      fwd_val = result_w;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall/flush control and operand forwarding.
// Only XLEN=32 is supported.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN = id_ex_stage_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StallE,
  input  logic            FlushE,
  input  logic            ValidD,
  input  logic            RegWriteD,
  input  logic            MemWriteD,
  input  logic            BranchD,
  input  logic            JumpD,
  input  logic            ALUSrcD,
  input  logic [1:0]      ResultSrcD,
  input  logic [2:0]      ALUControlD,
  input  logic [XLEN-1:0] RD1D,
  input  logic [XLEN-1:0] RD2D,
  input  logic [XLEN-1:0] ImmExtD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic [4:0]      Rs1D,
  input  logic [4:0]      Rs2D,
  input  logic [4:0]      RdD,
  input  logic            RegWriteM,
  input  logic [4:0]      RdM,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  output logic [XLEN-1:0] SrcAE,
  output logic [XLEN-1:0] SrcBE,
  output logic [2:0]      ALUControlE,
  output logic [XLEN-1:0] WriteDataE,
  output logic            ValidE,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            BranchE,
  output logic            JumpE,
  output logic [1:0]      ResultSrcE,
  output logic [4:0]      RdE,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [1:0]      ForwardAE,
  output logic [1:0]      ForwardBE
);

  ex_regs_t ex_q;
  ex_regs_t ex_d;

  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;

  // Next E contents: flush beats stall, stall holds, otherwise capture D.
  always_comb begin
    ex_d = ex_q;
    if (FlushE) begin
      ex_d = EX_BUBBLE;
    end else if (!StallE) begin
      ex_d.valid       = ValidD;
      ex_d.reg_write   = RegWriteD;
      ex_d.result_src  = ResultSrcD;
      ex_d.mem_write   = MemWriteD;
      ex_d.branch      = BranchD;
      ex_d.jump        = JumpD;
      ex_d.alu_control = ALUControlD;
      ex_d.alu_src     = ALUSrcD;
      ex_d.rd1         = RD1D;
      ex_d.rd2         = RD2D;
      ex_d.pc          = PCD;
      ex_d.imm_ext     = ImmExtD;
      ex_d.pc_plus4    = PCPlus4D;
      ex_d.rs1         = Rs1D;
      ex_d.rs2         = Rs2D;
      ex_d.rd          = RdD;
    end
  end

  // E-stage register; reset overrides both stall and flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= EX_BUBBLE;
    end else begin
      ex_q <= ex_d;
    end
  end

  forward_unit u_fwd_a (
    .valid_e      (ex_q.valid),
    .rs_e         (ex_q.rs1),
    .reg_val_e    (ex_q.rd1),
    .reg_write_m  (RegWriteM),
    .rd_m         (RdM),
    .alu_result_m (ALUResultM),
    .reg_write_w  (RegWriteW),
    .rd_w         (RdW),
    .result_w     (ResultW),
    .fwd_sel      (ForwardAE),
    .fwd_val      (fwd_a)
  );

  forward_unit u_fwd_b (
    .valid_e      (ex_q.valid),
    .rs_e         (ex_q.rs2),
    .reg_val_e    (ex_q.rd2),
    .reg_write_m  (RegWriteM),
    .rd_m         (RdM),
    .alu_result_m (ALUResultM),
    .reg_write_w  (RegWriteW),
    .rd_w         (RdW),
    .result_w     (ResultW),
    .fwd_sel      (ForwardBE),
    .fwd_val      (fwd_b)
  );

  // Store data always takes forwarded B; the immediate only feeds the ALU.
  always_comb begin
    SrcAE      = fwd_a;
    SrcBE      = ex_q.alu_src ? ex_q.imm_ext : fwd_b;
    WriteDataE = fwd_b;
  end

  assign ALUControlE = ex_q.alu_control;
  assign ValidE      = ex_q.valid;
  assign RegWriteE   = ex_q.reg_write;
  assign MemWriteE   = ex_q.mem_write;
  assign BranchE     = ex_q.branch;
  assign JumpE       = ex_q.jump;
  assign ResultSrcE  = ex_q.result_src;
  assign RdE         = ex_q.rd;
  assign Rs1E        = ex_q.rs1;
  assign Rs2E        = ex_q.rs2;
  assign PCE         = ex_q.pc;
  assign PCPlus4E    = ex_q.pc_plus4;
  assign ImmExtE     = ex_q.imm_ext;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: behavioural model checked every cycle plus directed literal checks.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, StallE, FlushE;
  logic        ValidD, RegWriteD, MemWriteD, BranchD, JumpD, ALUSrcD;
  logic [1:0]  ResultSrcD;
  logic [2:0]  ALUControlD;
  logic [31:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic        RegWriteM, RegWriteW;
  logic [4:0]  RdM, RdW;
  logic [31:0] ALUResultM, ResultW;

  logic [31:0] SrcAE, SrcBE, WriteDataE, PCE, PCPlus4E, ImmExtE;
  logic [2:0]  ALUControlE;
  logic        ValidE, RegWriteE, MemWriteE, BranchE, JumpE;
  logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
  logic [4:0]  RdE, Rs1E, Rs2E;

  int errors = 0;
  int checks = 0;
  bit model_live = 1'b0;

  id_ex_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE),
    .ValidD(ValidD), .RegWriteD(RegWriteD), .MemWriteD(MemWriteD),
    .BranchD(BranchD), .JumpD(JumpD), .ALUSrcD(ALUSrcD),
    .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD),
    .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .RegWriteM(RegWriteM), .RdM(RdM), .ALUResultM(ALUResultM),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .ALUControlE(ALUControlE), .WriteDataE(WriteDataE),
    .ValidE(ValidE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .BranchE(BranchE), .JumpE(JumpE), .ResultSrcE(ResultSrcE),
    .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the E stage is a snapshot of the last accepted D bundle.
  logic        m_valid, m_rw, m_mw, m_br, m_jp, m_asrc;
  logic [1:0]  m_rsrc;
  logic [2:0]  m_alu;
  logic [31:0] m_rd1, m_rd2, m_imm, m_pc, m_pc4;
  logic [4:0]  m_rs1, m_rs2, m_rd;

  task automatic model_clear();
    {m_valid, m_rw, m_mw, m_br, m_jp, m_asrc} = '0;
    m_rsrc = '0; m_alu = '0;
    m_rd1 = '0; m_rd2 = '0; m_imm = '0; m_pc = '0; m_pc4 = '0;
    m_rs1 = '0; m_rs2 = '0; m_rd = '0;
  endtask

  always @(posedge clk) begin
    if (rst || FlushE) begin
      model_clear();
    end else if (!StallE) begin
      m_valid = ValidD; m_rw = RegWriteD; m_mw = MemWriteD; m_br = BranchD;
      m_jp = JumpD; m_asrc = ALUSrcD; m_rsrc = ResultSrcD; m_alu = ALUControlD;
      m_rd1 = RD1D; m_rd2 = RD2D; m_imm = ImmExtD; m_pc = PCD; m_pc4 = PCPlus4D;
      m_rs1 = Rs1D; m_rs2 = Rs2D; m_rd = RdD;
    end
    model_live = 1'b1;
  end

  function automatic logic [1:0] exp_sel(input logic [4:0] rs);
    if (m_valid && RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (m_valid && RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] exp_val(input logic [4:0] rs, input logic [31:0] regv);
    case (exp_sel(rs))
      2'b10:   return ALUResultM;
      2'b01:   return ResultW;
      default: return regv;
    endcase
  endfunction

  // Compare every cycle, shortly after the edge, against the model.
  always @(posedge clk) begin
    #2;
    if (model_live) begin
      check("m_ValidE", ValidE, m_valid);
      check("m_ctrl", {RegWriteE, MemWriteE, BranchE, JumpE, ResultSrcE, ALUControlE},
            {m_rw, m_mw, m_br, m_jp, m_rsrc, m_alu});
      check("m_regs", {Rs1E, Rs2E, RdE}, {m_rs1, m_rs2, m_rd});
      check("m_PCE", PCE, m_pc);
      check("m_PCPlus4E", PCPlus4E, m_pc4);
      check("m_ImmExtE", ImmExtE, m_imm);
      check("m_ForwardAE", ForwardAE, exp_sel(m_rs1));
      check("m_ForwardBE", ForwardBE, exp_sel(m_rs2));
      check("m_SrcAE", SrcAE, exp_val(m_rs1, m_rd1));
      check("m_SrcBE", SrcBE, m_asrc ? m_imm : exp_val(m_rs2, m_rd2));
      check("m_WriteDataE", WriteDataE, exp_val(m_rs2, m_rd2));
    end
  end

  task automatic set_d(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
                       input logic asrc, input logic [31:0] pc);
    ValidD = 1'b1; Rs1D = rs1; Rs2D = rs2; RdD = rd;
    RD1D = rd1; RD2D = rd2; ImmExtD = imm; ALUSrcD = asrc;
    PCD = pc; PCPlus4D = pc + 32'd4;
  endtask

  task automatic edge_then_settle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; StallE = 0; FlushE = 0;
    ValidD = 1; RegWriteD = 1; MemWriteD = 1; BranchD = 1; JumpD = 1; ALUSrcD = 1;
    ResultSrcD = 2'b10; ALUControlD = 3'b101;
    RD1D = 32'h11; RD2D = 32'h22; ImmExtD = 32'h33; PCD = 32'h100; PCPlus4D = 32'h104;
    Rs1D = 5'd1; Rs2D = 5'd2; RdD = 5'd3;
    RegWriteM = 0; RdM = 0; ALUResultM = 0; RegWriteW = 0; RdW = 0; ResultW = 0;

    // Reset held two cycles with a valid instruction on D.
    edge_then_settle();
    edge_then_settle();
    check("rst_ValidE", ValidE, 0);
    check("rst_SrcAE", SrcAE, 0);
    check("rst_SrcBE", SrcBE, 0);
    check("rst_PCE", PCE, 0);
    check("rst_fwd", {ForwardAE, ForwardBE}, 0);

    // First edge after release loads D: plain operands, no forwarding.
    @(negedge clk);
    rst = 0; RegWriteD = 0; MemWriteD = 0; BranchD = 0; JumpD = 0;
    ResultSrcD = 2'b00; ALUControlD = 3'b000;
    set_d(5'd1, 5'd2, 5'd8, 32'd5, 32'd7, 32'h0, 1'b0, 32'h200);
    edge_then_settle();
    check("load_ValidE", ValidE, 1);
    check("load_SrcAE", SrcAE, 32'd5);
    check("load_SrcBE", SrcBE, 32'd7);
    check("load_fwd", {ForwardAE, ForwardBE}, 4'b0000);
    check("load_PCPlus4E", PCPlus4E, 32'h204);

    // Both M and W target x3: M wins.
    @(negedge clk);
    set_d(5'd3, 5'd9, 5'd10, 32'h99, 32'h66, 32'h0, 1'b0, 32'h300);
    RdM = 5'd3; RegWriteM = 1; ALUResultM = 32'h10;
    RdW = 5'd3; RegWriteW = 1; ResultW = 32'h20;
    edge_then_settle();
    check("dbl_ForwardAE", ForwardAE, 2'b10);
    check("dbl_SrcAE", SrcAE, 32'h10);
    check("dbl_SrcBE", SrcBE, 32'h66);

    // Same E contents held; M producer drops, W now supplies A combinationally.
    @(negedge clk);
    StallE = 1; RegWriteM = 0; RD1D = 32'hBAD;
    edge_then_settle();
    check("wb_ForwardAE", ForwardAE, 2'b01);
    check("wb_SrcAE", SrcAE, 32'h20);

    // Store with immediate: B goes to WriteData via W forward, SrcB takes immediate.
    @(negedge clk);
    StallE = 0; ALUControlD = 3'b111; MemWriteD = 1;
    set_d(5'd6, 5'd4, 5'd0, 32'h1, 32'h77, 32'hFFFF_FFFC, 1'b1, 32'h400);
    RdW = 5'd4; RegWriteW = 1; ResultW = 32'h55;
    edge_then_settle();
    check("st_SrcBE", SrcBE, 32'hFFFF_FFFC);
    check("st_WriteDataE", WriteDataE, 32'h55);
    check("st_ForwardBE", ForwardBE, 2'b01);
    check("st_ALUControlE", ALUControlE, 3'b111);

    // x0 is never forwarded.
    @(negedge clk);
    MemWriteD = 0; ALUControlD = 3'b001;
    set_d(5'd0, 5'd0, 5'd5, 32'h1234, 32'h5678, 32'h0, 1'b0, 32'h500);
    RdM = 5'd0; RegWriteM = 1; ALUResultM = 32'hDEAD;
    RdW = 5'd0; RegWriteW = 1; ResultW = 32'hBEEF;
    edge_then_settle();
    check("x0_ForwardAE", ForwardAE, 2'b00);
    check("x0_SrcAE", SrcAE, 32'h1234);
    check("x0_WriteDataE", WriteDataE, 32'h5678);

    // Load a writing store, then stall three cycles while D churns.
    @(negedge clk);
    RegWriteM = 0; RegWriteW = 0; RegWriteD = 1; MemWriteD = 1;
    set_d(5'd7, 5'd8, 5'd9, 32'hA, 32'hB, 32'hC, 1'b0, 32'h600);
    edge_then_settle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      StallE = 1;
      set_d(5'd11 + 5'(i), 5'd12, 5'd13, 32'(i), 32'(i), 32'(i), 1'b1, 32'h700 + 32'(i));
      edge_then_settle();
      check("stall_PCE", PCE, 32'h600);
      check("stall_SrcAE", SrcAE, 32'hA);
    end

    // Flush and stall together: bubble.
    @(negedge clk);
    FlushE = 1;
    edge_then_settle();
    check("flush_ValidE", ValidE, 0);
    check("flush_RegWriteE", RegWriteE, 0);
    check("flush_MemWriteE", MemWriteE, 0);
    check("flush_ALUControlE", ALUControlE, 3'b000);

    // Reset during a stall discards the held instruction.
    @(negedge clk);
    FlushE = 0; StallE = 0;
    set_d(5'd1, 5'd2, 5'd3, 32'h42, 32'h43, 32'h0, 1'b0, 32'h800);
    edge_then_settle();
    check("pre_rst_ValidE", ValidE, 1);
    @(negedge clk);
    StallE = 1; rst = 1;
    edge_then_settle();
    check("rst_stall_ValidE", ValidE, 0);
    check("rst_stall_PCE", PCE, 0);

    // Release: next edge loads normally.
    @(negedge clk);
    rst = 0; StallE = 0;
    set_d(5'd2, 5'd3, 5'd4, 32'h90, 32'h91, 32'h0, 1'b0, 32'h900);
    edge_then_settle();
    check("rel_PCE", PCE, 32'h900);
    check("rel_SrcAE", SrcAE, 32'h90);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
